mem_writeback: RTL

MEM_WRITEBACK -- requirements
Module: mem_writeback

---
 rtl/mem_writeback.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mem_writeback
// Description : Memory/writeback stage. Retires ALU results straight to the
//               register file and runs load/store accesses over a req/ack
//               handshake with a 16-cycle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_out,
    input  logic [15:0] instruction_in,
    input  logic        condition_in,
    input  logic        LS_in,
    input  logic [15:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        mem_err,
    output logic [15:0] retired
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_t;

    localparam logic [3:0] c_WAIT_MAX = 4'd15;

    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [3:0]  r_rd;
    logic        r_is_load;
    logic [3:0]  r_wait_cnt;
    logic        r_rf_we;
    logic [3:0]  r_rf_waddr;
    logic [15:0] r_rf_wdata;
    logic        r_mem_err;
    logic [15:0] r_retired;

    logic        w_accept;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign mem_err   = r_mem_err;
    assign retired   = r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_rd        <= 4'd0;
            r_is_load   <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= 4'd0;
            r_rf_wdata  <= 16'h0000;
            r_mem_err   <= 1'b0;
            r_retired   <= 16'h0000;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Squashed instructions (condition_in=0) are accepted and dropped.
                    if (w_accept && condition_in) begin
                        if (!LS_in) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= instruction_in[15:12];
                            r_rf_wdata <= alu_out;
                            r_retired  <= r_retired + 16'd1;
                        end else begin
                            r_mem_addr  <= alu_out;
                            r_mem_we    <= ~instruction_in[11];
                            r_mem_wdata <= store_data;
                            r_rd        <= instruction_in[15:12];
                            r_is_load   <= instruction_in[11];
                            r_mem_req   <= 1'b1;
                            r_wait_cnt  <= 4'd0;
                            r_state     <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_retired <= r_retired + 16'd1;
                        r_state   <= IDLE;
                        if (r_is_load) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_rd;
                            r_rf_wdata <= mem_rdata;
                        end
                    end else if (r_wait_cnt == c_WAIT_MAX) begin
                        // Sixteenth unacknowledged cycle: give up and flag it.
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
